// File: rtl/time_base_pkg.sv
// Shared constants and elaboration-time helpers for the TroisBriques time base
// and its sibling blocks.
package time_base_pkg;

    localparam int CLK_HZ = 50_000_000;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = (v > 1) ? v - 1 : 0;
        for (int i = 0; i < 32; i++) begin
            if (x > 0) begin
                r = r + 1;
                x = x >> 1;
            end
        end
        return r;
    endfunction

    // Counter width for a divide-by-n counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Fall period in clk cycles for a given level, floored at min_cycles.
    function automatic int fall_period(input int level, input int base, input int min_cycles);
        int p;
        p = (level >= 31) ? 0 : (base >>> level);
        return (p < min_cycles) ? min_cycles : p;
    endfunction

endpackage

// File: rtl/time_base_multi_tick_divider.sv
// Enable-gated modulo counter with a registered single-cycle tick; the terminal
// count comes in on a port so one channel can change period at run time.
module tick_divider
    import time_base_pkg::*;
#(
    parameter int N = 2,
    localparam int W = cnt_w(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable_i,
    input  logic         clear_i,
    input  logic [W-1:0] term_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         tick_q;
    logic         tick_d;

    // >= rather than == so a period that shrinks below the current count
    // still terminates on the very next enabled edge.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (cnt_q >= term_i) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/time_base_multi.sv
// Game time base: pixel, scan and brick-fall tick strobes plus the difficulty
// level register driven by a synchronised button, a direct load and soft drop.
module time_base_multi
    import time_base_pkg::*;
#(
    parameter int PIX_DIV          = 2,
    parameter int SEG_DIV          = CLK_HZ / 20_000,
    parameter int FALL_BASE_CYCLES = CLK_HZ,
    parameter int FALL_MIN_CYCLES  = 3_125_000,
    parameter int NUM_LEVELS       = 8,
    parameter int LEVEL_WRAP       = 0,
    localparam int LEVEL_W         = clog2(NUM_LEVELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               level_up_btn,
    input  logic               level_load,
    input  logic [LEVEL_W-1:0] level_in,
    input  logic               soft_drop,
    output logic               pix_tick,
    output logic               seg_tick,
    output logic               fall_tick,
    output logic [LEVEL_W-1:0] level,
    output logic               level_max
);

    localparam int PIX_W       = cnt_w(PIX_DIV);
    localparam int SEG_W       = cnt_w(SEG_DIV);
    localparam int FALL_W      = cnt_w(FALL_BASE_CYCLES);
    localparam int LEVEL_SLOTS = 1 << LEVEL_W;

    localparam logic [LEVEL_W-1:0] LEVEL_TOP     = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [FALL_W-1:0]  FALL_MIN_TERM = FALL_W'(FALL_MIN_CYCLES - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic               prev_q;
    logic               armed_q;
    logic [1:0]         fill_q;
    logic               up_ev;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;
    logic               level_change;
    logic [FALL_W-1:0]  fall_term [LEVEL_SLOTS];
    logic [FALL_W-1:0]  fall_term_sel;

    // Terminal counts per level; unused slots above the top level repeat it.
    for (genvar gi = 0; gi < LEVEL_SLOTS; gi++) begin : g_fall_term
        localparam int LVL = (gi < NUM_LEVELS) ? gi : NUM_LEVELS - 1;
        assign fall_term[gi] = FALL_W'(fall_period(LVL, FALL_BASE_CYCLES, FALL_MIN_CYCLES) - 1);
    end

    // fill_q marks when sync2_q holds a real sample; armed_q needs one real low
    // so a button held through reset release cannot count as a press.
    assign up_ev = sync2_q & ~prev_q & armed_q;

    always_comb begin
        level_d = level_q;
        if (level_load) begin
            level_d = (level_in > LEVEL_TOP) ? LEVEL_TOP : level_in;
        end else if (up_ev) begin
            if (level_q != LEVEL_TOP) begin
                level_d = level_q + LEVEL_W'(1);
            end else if (LEVEL_WRAP != 0) begin
                level_d = '0;
            end
        end
    end

    assign level_change  = (level_d != level_q);
    assign fall_term_sel = soft_drop ? FALL_MIN_TERM : fall_term[level_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            fill_q  <= 2'b00;
            level_q <= '0;
        end else begin
            sync1_q <= level_up_btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            armed_q <= armed_q | (fill_q[1] & ~sync2_q);
            fill_q  <= {fill_q[0], 1'b1};
            level_q <= level_d;
        end
    end

    tick_divider #(.N(PIX_DIV)) u_pix (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable),
        .clear_i  (1'b0),
        .term_i   (PIX_W'(PIX_DIV - 1)),
        .tick_o   (pix_tick)
    );

    tick_divider #(.N(SEG_DIV)) u_seg (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable),
        .clear_i  (1'b0),
        .term_i   (SEG_W'(SEG_DIV - 1)),
        .tick_o   (seg_tick)
    );

    tick_divider #(.N(FALL_BASE_CYCLES)) u_fall (
        .clk      (clk),
        .reset    (reset),
        .enable_i (enable),
        .clear_i  (level_change),
        .term_i   (fall_term_sel),
        .tick_o   (fall_tick)
    );

    assign level     = level_q;
    assign level_max = (level_q == LEVEL_TOP);

endmodule

// File: tb/tb_time_base_multi.sv
// Directed bench: a saturating 8-level instance and a wrapping 6-level instance
// share every input; both use short periods so fall timing is quick to observe.
module tb_time_base_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       level_up_btn = 1'b0;
    logic       level_load = 1'b0;
    logic [2:0] level_in = 3'd0;
    logic       soft_drop = 1'b0;

    logic       pix_a, seg_a, fall_a, max_a;
    logic [2:0] level_a;
    logic       pix_w, seg_w, fall_w, max_w;
    logic [2:0] level_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    time_base_multi #(
        .PIX_DIV(2), .SEG_DIV(5), .FALL_BASE_CYCLES(64), .FALL_MIN_CYCLES(8),
        .NUM_LEVELS(8), .LEVEL_WRAP(0)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .level_up_btn(level_up_btn),
        .level_load(level_load), .level_in(level_in), .soft_drop(soft_drop),
        .pix_tick(pix_a), .seg_tick(seg_a), .fall_tick(fall_a),
        .level(level_a), .level_max(max_a)
    );

    time_base_multi #(
        .PIX_DIV(2), .SEG_DIV(5), .FALL_BASE_CYCLES(64), .FALL_MIN_CYCLES(8),
        .NUM_LEVELS(6), .LEVEL_WRAP(1)
    ) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .level_up_btn(level_up_btn),
        .level_load(level_load), .level_in(level_in), .soft_drop(soft_drop),
        .pix_tick(pix_w), .seg_tick(seg_w), .fall_tick(fall_w),
        .level(level_w), .level_max(max_w)
    );

    typedef struct {
        logic en;
        logic pix;
        logic seg;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        level_up_btn = 1'b0;
        level_load = 1'b0;
        level_in = 3'd0;
        soft_drop = 1'b0;
        step();
        step();
        reset = 1'b0;
        enable = 1'b1;
    endtask

    // Edges until the next fall tick of each instance; limit+1 when no tick
    // arrives within the window.
    task automatic count_ticks(input int limit, input bit need_a, input bit need_w,
                               output int na, output int nw);
        na = limit + 1;
        nw = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (fall_a && na > limit) na = i;
            if (fall_w && nw > limit) nw = i;
            if ((!need_a || na <= limit) && (!need_w || nw <= limit)) break;
        end
    endtask

    task automatic press();
        level_up_btn = 1'b1;
        repeat (4) step();
        level_up_btn = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nw, seen;

        vecs[0]  = '{en: 1'b1, pix: 1'b0, seg: 1'b0};
        vecs[1]  = '{en: 1'b1, pix: 1'b1, seg: 1'b0};
        vecs[2]  = '{en: 1'b1, pix: 1'b0, seg: 1'b0};
        vecs[3]  = '{en: 1'b1, pix: 1'b1, seg: 1'b0};
        vecs[4]  = '{en: 1'b1, pix: 1'b0, seg: 1'b1};
        vecs[5]  = '{en: 1'b1, pix: 1'b1, seg: 1'b0};
        vecs[6]  = '{en: 1'b0, pix: 1'b0, seg: 1'b0};
        vecs[7]  = '{en: 1'b0, pix: 1'b0, seg: 1'b0};
        vecs[8]  = '{en: 1'b1, pix: 1'b0, seg: 1'b0};
        vecs[9]  = '{en: 1'b1, pix: 1'b1, seg: 1'b0};
        vecs[10] = '{en: 1'b1, pix: 1'b0, seg: 1'b0};
        vecs[11] = '{en: 1'b1, pix: 1'b1, seg: 1'b1};
        vecs[12] = '{en: 1'b1, pix: 1'b0, seg: 1'b0};

        // Reset held with enable high: everything stays at zero.
        reset = 1'b1;
        enable = 1'b1;
        repeat (3) step();
        check("reset pix", int'(pix_a), 0);
        check("reset seg", int'(seg_a), 0);
        check("reset fall", int'(fall_a), 0);
        check("reset level", int'(level_a), 0);
        check("reset level_max", int'(max_a), 0);
        check("reset pix_w", int'(pix_w), 0);
        check("reset seg_w", int'(seg_w), 0);
        check("reset level_w", int'(level_w), 0);
        check("reset level_max_w", int'(max_w), 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            enable = vecs[i].en;
            step();
            check($sformatf("vec%0d pix", i), int'(pix_a), int'(vecs[i].pix));
            check($sformatf("vec%0d seg", i), int'(seg_a), int'(vecs[i].seg));
        end

        // Level 0 fall period.
        do_reset();
        count_ticks(100, 1'b1, 1'b1, na, nw);
        check("L0 first fall", na, 64);
        check("L0 first fall_w", nw, 64);
        count_ticks(100, 1'b1, 1'b0, na, nw);
        check("L0 second fall", na, 64);

        // Held button: one level step, fall counter cleared at the change.
        do_reset();
        repeat (20) step();
        level_up_btn = 1'b1;
        repeat (3) step();
        check("btn level after 3 edges", int'(level_a), 1);
        check("btn level_w after 3 edges", int'(level_w), 1);
        repeat (7) step();
        level_up_btn = 1'b0;
        count_ticks(100, 1'b1, 1'b1, na, nw);
        check("L1 fall after clear", na, 25);
        check("L1 fall_w after clear", nw, 25);
        check("btn held gives one step", int'(level_a), 1);

        // Ten presses: saturate vs wrap.
        do_reset();
        repeat (4) step();
        for (int p = 1; p <= 10; p++) begin
            press();
            if (p == 5) begin
                check("wrap level_w p5", int'(level_w), 5);
                check("wrap level_max_w p5", int'(max_w), 1);
            end
            if (p == 6) begin
                check("sat level p6", int'(level_a), 6);
                check("sat level_max p6", int'(max_a), 0);
                check("wrap level_w p6", int'(level_w), 0);
                check("wrap level_max_w p6", int'(max_w), 0);
            end
        end
        check("sat level p10", int'(level_a), 7);
        check("sat level_max p10", int'(max_a), 1);
        check("wrap level_w p10", int'(level_w), 4);
        count_ticks(20, 1'b1, 1'b0, na, nw);
        count_ticks(20, 1'b1, 1'b0, na, nw);
        check("L7 fall period", na, 8);
        level_up_btn = 1'b1;
        count_ticks(20, 1'b1, 1'b0, na, nw);
        check("saturated press keeps phase", na, 8);
        level_up_btn = 1'b0;
        repeat (4) step();
        check("saturated level holds", int'(level_a), 7);

        // Soft drop from count 40 at level 0.
        do_reset();
        repeat (40) step();
        soft_drop = 1'b1;
        step();
        check("soft drop immediate", int'(fall_a), 1);
        count_ticks(20, 1'b1, 1'b0, na, nw);
        check("soft drop period 1", na, 8);
        count_ticks(20, 1'b1, 1'b0, na, nw);
        check("soft drop period 2", na, 8);
        soft_drop = 1'b0;
        count_ticks(100, 1'b1, 1'b0, na, nw);
        check("after release period", na, 64);

        // Load coinciding with up_ev: load wins and clamps.
        do_reset();
        repeat (30) step();
        level_up_btn = 1'b1;
        step();
        step();
        level_load = 1'b1;
        level_in = 3'd7;
        step();
        level_load = 1'b0;
        check("load beats up_ev", int'(level_a), 7);
        check("load clamps level_w", int'(level_w), 5);
        check("load clamp level_max_w", int'(max_w), 1);
        count_ticks(20, 1'b1, 1'b1, na, nw);
        check("load clears fall", na, 8);
        check("load clears fall_w", nw, 8);
        check("no extra up_ev", int'(level_a), 7);
        level_up_btn = 1'b0;
        repeat (4) step();
        count_ticks(20, 1'b1, 1'b1, na, nw);
        level_load = 1'b1;
        level_in = 3'd7;
        step();
        level_load = 1'b0;
        step();
        step();
        count_ticks(20, 1'b1, 1'b1, na, nw);
        check("same-value reload keeps phase", na, 5);
        check("clamped reload keeps phase_w", nw, 5);

        // Pause mid-count.
        do_reset();
        repeat (21) step();
        enable = 1'b0;
        seen = 0;
        repeat (100) begin
            step();
            seen += int'(pix_a) + int'(seg_a) + int'(fall_a);
        end
        check("ticks during pause", seen, 0);
        enable = 1'b1;
        step();
        check("pix tick on resume", int'(pix_a), 1);
        count_ticks(100, 1'b1, 1'b0, na, nw);
        check("fall after resume", na, 42);

        // Reset mid-run with the button held through release.
        level_load = 1'b1;
        level_in = 3'd3;
        step();
        level_load = 1'b0;
        check("load level 3", int'(level_a), 3);
        reset = 1'b1;
        level_up_btn = 1'b1;
        step();
        check("mid reset level", int'(level_a), 0);
        check("mid reset level_max", int'(max_a), 0);
        check("mid reset pix", int'(pix_a), 0);
        check("mid reset fall", int'(fall_a), 0);
        reset = 1'b0;
        repeat (10) step();
        check("held through reset no event", int'(level_a), 0);
        level_up_btn = 1'b0;
        repeat (4) step();
        press();
        check("press after release", int'(level_a), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
